// File: rtl/dilithium_pkg.sv
// Shared constants, FSM state type and coefficient helpers for the
// Dilithium eta-bounded polynomial packer.
package dilithium_pkg;

    localparam int unsigned N               = 256;
    localparam int unsigned COEFF_W         = 32;
    localparam int unsigned POLY_W          = N * COEFF_W;
    localparam int unsigned ETA2_PACK_BYTES = 96;
    localparam int unsigned ETA4_PACK_BYTES = 128;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } pack_state_e;

    function automatic int unsigned eta_pack_bytes(input int unsigned eta);
        return (eta == 4) ? ETA4_PACK_BYTES : ETA2_PACK_BYTES;
    endfunction

    function automatic logic coeff_out_of_range(input logic [COEFF_W-1:0] a,
                                                input int unsigned eta);
        int e;
        e = int'(eta);
        return (signed'(a) > e) || (signed'(a) < -e);
    endfunction

    // t = eta - a; callers keep the low 3 or 4 bits.
    function automatic logic [3:0] eta_t(input logic [COEFF_W-1:0] a,
                                         input int unsigned eta);
        return 4'(COEFF_W'(eta) - a);
    endfunction

endpackage

// File: rtl/eta_pack_byte.sv
// Combinational formatter: returns packed byte `idx` of the polynomial and
// flags any out-of-range coefficient among those feeding that byte.
module eta_pack_byte
    import dilithium_pkg::*;
#(
    parameter int unsigned ETA = 2
) (
    input  logic [POLY_W-1:0] poly,
    input  logic [7:0]        idx,
    output logic [7:0]        byte_val,
    output logic              range_err
);

    logic [7:0]         grp;
    logic [1:0]         sub;
    logic [23:0]        word;
    logic [COEFF_W-1:0] c;
    logic [3:0]         t;
    int unsigned        base;

    always_comb begin
        byte_val  = '0;
        range_err = 1'b0;
        grp       = '0;
        sub       = '0;
        word      = '0;
        c         = '0;
        t         = '0;
        base      = 0;
        if (ETA == 4) begin
            for (int unsigned j = 0; j < 2; j++) begin
                base               = (2 * 32'(idx) + j) * COEFF_W;
                c                  = poly[base +: COEFF_W];
                t                  = eta_t(c, ETA);
                byte_val[4*j +: 4] = t;
                range_err          = range_err | coeff_out_of_range(c, ETA);
            end
        end else begin
            // Eight 3-bit fields form a 24-bit group; idx selects group and byte within it.
            grp = idx / 8'd3;
            sub = 2'(idx % 8'd3);
            for (int unsigned j = 0; j < 8; j++) begin
                base           = (8 * 32'(grp) + j) * COEFF_W;
                c              = poly[base +: COEFF_W];
                t              = eta_t(c, ETA);
                word[3*j +: 3] = t[2:0];
                range_err      = range_err | coeff_out_of_range(c, ETA);
            end
            byte_val = word[8*sub +: 8];
        end
    end

endmodule

// File: rtl/poly_eta_pack.sv
// Streams a latched 256-coefficient polynomial out as eta-packed bytes over a
// valid/ready handshake, pulsing done after the final byte.
module poly_eta_pack
    import dilithium_pkg::*;
#(
    parameter int unsigned ETA = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [POLY_W-1:0] a_in,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              done,
    output logic              err
);

    localparam int unsigned NBYTES   = eta_pack_bytes(ETA);
    localparam logic [7:0]  LAST_IDX = 8'(NBYTES - 1);

    pack_state_e       state_q, state_d;
    logic [POLY_W-1:0] poly_q, poly_d;
    logic [7:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        fmt_byte;
    logic              fmt_err;

    eta_pack_byte #(.ETA(ETA)) u_fmt (
        .poly      (poly_q),
        .idx       (idx_q),
        .byte_val  (fmt_byte),
        .range_err (fmt_err)
    );

    always_comb begin
        state_d = state_q;
        poly_d  = poly_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    poly_d  = a_in;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            SEND: begin
                err_d = err_q | fmt_err;
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
        poly_q <= poly_d;
    end

    // Byte is formatted straight from the latched poly; gating keeps it zero when idle.
    assign byte_out   = valid_q ? fmt_byte : '0;
    assign byte_valid = valid_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
